vga_pic_loader: RTL and testbench

//  Write side of the 64x64 1-bit-per-colour picture memory scanned by the VGA control path.

---
 rtl/vga_pic_pkg.sv | 14 +
 rtl/vga_row_assembler.sv | 54 +++++
 rtl/vga_pic_loader.sv | 127 ++++++++++++
 tb/tb_vga_pic_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pic_pkg.sv
// Shared constants and state encoding for the picture-memory loader.
package vga_pic_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         ROW_BYTES         = 24;
  localparam int         LANE_BYTES        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/vga_row_assembler.sv
// Collects 24 bytes of one row into R/G/B shift lanes; first byte of a lane ends up in bits 63:56.
module vga_row_assembler
  import vga_pic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [63:0] red_word,
  output logic [63:0] green_word,
  output logic [63:0] blue_word,
  output logic        row_done
);

  logic [4:0]  idx;
  logic [63:0] red_q;
  logic [63:0] green_q;
  logic [63:0] blue_q;

  // Words include the byte being accepted this cycle, so the row can be latched on byte 23.
  always_comb begin
    red_word   = red_q;
    green_word = green_q;
    blue_word  = blue_q;
    if (byte_vld) begin
      if (idx < 5'(LANE_BYTES))
        red_word = {red_q[55:0], byte_in};
      else if (idx < 5'(2 * LANE_BYTES))
        green_word = {green_q[55:0], byte_in};
      else
        blue_word = {blue_q[55:0], byte_in};
    end
  end

  assign row_done = byte_vld && (idx == 5'(ROW_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx <= '0;
    else if (clear)
      idx <= '0;
    else if (byte_vld)
      idx <= row_done ? 5'd0 : idx + 5'd1;
  end

  // Lanes are fully overwritten every row, so they carry no reset.
  always_ff @(posedge clk) begin
    red_q   <= red_word;
    green_q <= green_word;
    blue_q  <= blue_word;
  end

endmodule

// File: rtl/vga_pic_loader.sv
// UART byte stream to 64x64 RGB picture RAM writer with frame sync, XOR checksum and inter-byte timeout.
module vga_pic_loader
  import vga_pic_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int          ROWS           = 64,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Done_Sig,
  output logic        Wr_En_Sig,
  output logic [5:0]  Wr_Addr,
  output logic [63:0] Red_Wr_Data,
  output logic [63:0] Green_Wr_Data,
  output logic [63:0] Blue_Wr_Data,
  output logic        Busy_Sig,
  output logic        Done_Sig,
  output logic        Err_Sig
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t      state;
  logic [5:0]  row;
  logic [7:0]  chk;
  logic [TW-1:0] tcnt;

  logic        sync_hit;
  logic        byte_vld;
  logic        row_done;
  logic        expired;
  logic [63:0] red_word;
  logic [63:0] green_word;
  logic [63:0] blue_word;

  assign sync_hit = (state == IDLE) && Rx_Done_Sig && (Rx_Data == SYNC_BYTE);
  assign byte_vld = (state == RECV) && Rx_Done_Sig;
  assign expired  = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  vga_row_assembler u_row (
    .clk        (CLK),
    .rst_n      (RSTn),
    .clear      (sync_hit),
    .byte_vld   (byte_vld),
    .byte_in    (Rx_Data),
    .red_word   (red_word),
    .green_word (green_word),
    .blue_word  (blue_word),
    .row_done   (row_done)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= IDLE;
      row           <= '0;
      chk           <= '0;
      tcnt          <= '0;
      Wr_En_Sig     <= 1'b0;
      Wr_Addr       <= '0;
      Red_Wr_Data   <= '0;
      Green_Wr_Data <= '0;
      Blue_Wr_Data  <= '0;
      Busy_Sig      <= 1'b0;
      Done_Sig      <= 1'b0;
      Err_Sig       <= 1'b0;
    end else begin
      Wr_En_Sig <= 1'b0;
      Done_Sig  <= 1'b0;
      Err_Sig   <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_hit) begin
            state    <= RECV;
            row      <= '0;
            chk      <= '0;
            tcnt     <= '0;
            Busy_Sig <= 1'b1;
          end
        end
        RECV: begin
          if (Rx_Done_Sig) begin
            tcnt <= '0;
            chk  <= chk ^ Rx_Data;
            if (row_done) begin
              Red_Wr_Data   <= red_word;
              Green_Wr_Data <= green_word;
              Blue_Wr_Data  <= blue_word;
              Wr_Addr       <= row;
              Wr_En_Sig     <= 1'b1;
              row           <= row + 6'd1;
              if (row == LAST_ROW)
                state <= CHECK;
            end
          end else if (expired) begin
            Err_Sig  <= 1'b1;
            Busy_Sig <= 1'b0;
            tcnt     <= '0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          if (Rx_Done_Sig) begin
            Done_Sig <= (Rx_Data == chk);
            Err_Sig  <= (Rx_Data != chk);
            Busy_Sig <= 1'b0;
            tcnt     <= '0;
            state    <= IDLE;
          end else if (expired) begin
            Err_Sig  <= 1'b1;
            Busy_Sig <= 1'b0;
            tcnt     <= '0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pic_loader.sv
// Scoreboard bench for vga_pic_loader: expected row writes and frame results queued, monitor compares.
module tb_vga_pic_loader;

  localparam int TMO = 50;

  typedef struct packed {
    logic [5:0]  a;
    logic [63:0] r;
    logic [63:0] g;
    logic [63:0] b;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  Rx_Data = 8'h00;
  logic        Rx_Done_Sig = 1'b0;
  logic        Wr_En_Sig;
  logic [5:0]  Wr_Addr;
  logic [63:0] Red_Wr_Data;
  logic [63:0] Green_Wr_Data;
  logic [63:0] Blue_Wr_Data;
  logic        Busy_Sig;
  logic        Done_Sig;
  logic        Err_Sig;

  always #5 CLK = ~CLK;

  vga_pic_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .Rx_Data       (Rx_Data),
    .Rx_Done_Sig   (Rx_Done_Sig),
    .Wr_En_Sig     (Wr_En_Sig),
    .Wr_Addr       (Wr_Addr),
    .Red_Wr_Data   (Red_Wr_Data),
    .Green_Wr_Data (Green_Wr_Data),
    .Blue_Wr_Data  (Blue_Wr_Data),
    .Busy_Sig      (Busy_Sig),
    .Done_Sig      (Done_Sig),
    .Err_Sig       (Err_Sig)
  );

  int   checks = 0;
  int   fails = 0;
  int   nwrites = 0;
  int   ndone = 0;
  int   nerr = 0;
  logic [7:0] pay [0:1535];
  wr_t  wq[$];
  int   eq[$];
  wr_t  mon_e;
  int   mon_got;
  int   mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    fails++;
    $display("FAIL %s: DUT output with empty expectation queue", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a frame result.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (Wr_En_Sig) begin
        nwrites++;
        if (wq.size() == 0) unexpected("write");
        else begin
          mon_e = wq.pop_front();
          check("wr_addr", 64'(Wr_Addr), 64'(mon_e.a));
          check("red", Red_Wr_Data, mon_e.r);
          check("green", Green_Wr_Data, mon_e.g);
          check("blue", Blue_Wr_Data, mon_e.b);
        end
      end
      if (Done_Sig || Err_Sig) begin
        mon_got = (Done_Sig ? 1 : 0) + (Err_Sig ? 2 : 0);
        if (Done_Sig) ndone++;
        if (Err_Sig) nerr++;
        if (eq.size() == 0) unexpected("frame_result");
        else begin
          mon_exp = eq.pop_front();
          check("frame_result(1=done,2=err)", 64'(mon_got), 64'(mon_exp));
          check("busy_at_result", 64'(Busy_Sig), 64'd0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    Rx_Data = b;
    Rx_Done_Sig = 1'b1;
    @(negedge CLK);
    Rx_Done_Sig = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 64; r++)
      for (int i = 0; i < 24; i++)
        case (mode)
          0: pay[r*24+i] = 8'hFF;
          1: pay[r*24+i] = 8'((r * 7 + i * 13) & 255);
          default: pay[r*24+i] = 8'((r + i * 3) & 255) ^ 8'h5A;
        endcase
    if (mode == 1) begin
      for (int i = 0; i < 24; i++) pay[i] = 8'h00;
      pay[0] = 8'h80;
      pay[15] = 8'h01;
      for (int i = 16; i < 24; i++) pay[i] = 8'hA5;
    end
  endtask

  function automatic wr_t row_model(input int r);
    wr_t w;
    w.a = 6'(r);
    for (int i = 0; i < 8; i++) begin
      w.r[63-8*i -: 8] = pay[r*24+i];
      w.g[63-8*i -: 8] = pay[r*24+8+i];
      w.b[63-8*i -: 8] = pay[r*24+16+i];
    end
    return w;
  endfunction

  // Sends sync plus n payload bytes; a full frame also gets the checksum XORed with flip.
  task automatic send_frame(input int n, input logic [7:0] flip, input bit hand0, input int slow_at);
    logic [7:0] x;
    wr_t w;
    x = 8'h00;
    for (int k = 0; k < 1536; k++) x = x ^ pay[k];
    send(8'hA5, 0);
    check("busy_after_sync", 64'(Busy_Sig), 64'd1);
    for (int k = 0; k < n; k++) begin
      if (k % 24 == 23) begin
        if (hand0 && k == 23) begin
          w.a = 6'd0;
          w.r = 64'h8000_0000_0000_0000;
          w.g = 64'h0000_0000_0000_0001;
          w.b = 64'hA5A5_A5A5_A5A5_A5A5;
        end else w = row_model(k / 24);
        wq.push_back(w);
      end
      send(pay[k], (k == slow_at) ? TMO - 1 : 0);
    end
    if (n == 1536) begin
      eq.push_back(flip == 8'h00 ? 1 : 2);
      send(x ^ flip, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(Wr_En_Sig), 64'd0);
    check({tag, "_addr"}, 64'(Wr_Addr), 64'd0);
    check({tag, "_red"}, Red_Wr_Data, 64'd0);
    check({tag, "_green"}, Green_Wr_Data, 64'd0);
    check({tag, "_blue"}, Blue_Wr_Data, 64'd0);
    check({tag, "_busy"}, 64'(Busy_Sig), 64'd0);
    check({tag, "_done"}, 64'(Done_Sig), 64'd0);
    check({tag, "_err"}, 64'(Err_Sig), 64'd0);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int w0, d0, e0, cnt;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    // 1: junk ignored in IDLE, all-ones frame
    send(8'h00, 0);
    send(8'hFF, 2);
    check("idle_ignore_busy", 64'(Busy_Sig), 64'd0);
    check("idle_ignore_writes", 64'(nwrites), 64'd0);
    fill(0);
    w0 = nwrites; d0 = ndone;
    send_frame(1536, 8'h00, 1'b0, -1);
    repeat (4) @(negedge CLK);
    check("t1_writes", 64'(nwrites - w0), 64'd64);
    check("t1_done", 64'(ndone - d0), 64'd1);
    check("t1_busy_after", 64'(Busy_Sig), 64'd0);

    // 2: hand-computed first row, varied remaining rows
    fill(1);
    w0 = nwrites; d0 = ndone;
    send_frame(1536, 8'h00, 1'b1, -1);
    repeat (4) @(negedge CLK);
    check("t2_writes", 64'(nwrites - w0), 64'd64);
    check("t2_done", 64'(ndone - d0), 64'd1);

    // 3: corrupted checksum
    fill(2);
    w0 = nwrites; d0 = ndone; e0 = nerr;
    send_frame(1536, 8'h01, 1'b0, -1);
    repeat (4) @(negedge CLK);
    check("t3_writes", 64'(nwrites - w0), 64'd64);
    check("t3_err", 64'(nerr - e0), 64'd1);
    check("t3_no_done", 64'(ndone - d0), 64'd0);
    check("t3_busy_after", 64'(Busy_Sig), 64'd0);

    // 4: stall after 100 payload bytes
    w0 = nwrites; e0 = nerr;
    send_frame(100, 8'h00, 1'b0, -1);
    eq.push_back(2);
    cnt = 0;
    while (!Err_Sig && cnt < 200) begin
      @(negedge CLK);
      cnt++;
    end
    check("t4_timeout_latency", 64'(cnt), 64'(TMO));
    repeat (3) @(negedge CLK);
    check("t4_writes", 64'(nwrites - w0), 64'd4);
    check("t4_err", 64'(nerr - e0), 64'd1);
    check("t4_busy_after", 64'(Busy_Sig), 64'd0);
    fill(1);
    w0 = nwrites; d0 = ndone;
    send_frame(1536, 8'h00, 1'b0, -1);
    repeat (4) @(negedge CLK);
    check("t4_new_frame_writes", 64'(nwrites - w0), 64'd64);
    check("t4_new_frame_done", 64'(ndone - d0), 64'd1);

    // 5: strobe lands exactly on the expiry cycle
    fill(2);
    w0 = nwrites; d0 = ndone; e0 = nerr;
    send_frame(1536, 8'h00, 1'b0, 500);
    repeat (4) @(negedge CLK);
    check("t5_writes", 64'(nwrites - w0), 64'd64);
    check("t5_done", 64'(ndone - d0), 64'd1);
    check("t5_no_err", 64'(nerr - e0), 64'd0);

    // 6: reset in the middle of row 10
    w0 = nwrites;
    send_frame(10 * 24 + 5, 8'h00, 1'b0, -1);
    check("t6_writes_before_reset", 64'(nwrites - w0), 64'd10);
    RSTn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    fill(1);
    w0 = nwrites; d0 = ndone;
    send_frame(1536, 8'h00, 1'b0, -1);
    repeat (4) @(negedge CLK);
    check("t6_writes_after", 64'(nwrites - w0), 64'd64);
    check("t6_done", 64'(ndone - d0), 64'd1);

    check("write_queue_drained", 64'(wq.size()), 64'd0);
    check("result_queue_drained", 64'(eq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
